// File: rtl/md_unit_if.sv
// Interface bundling the md_unit issue, status and HI/LO read-back signals.
// Optional macro MD_CANCEL_EN adds the md_cancel flush input.
interface md_unit_if;
   logic        md_valid;
   logic [2:0]  md_ctrl;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic [31:0] md_result;
   logic        md_busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;
`ifdef MD_CANCEL_EN
   logic        md_cancel;

   modport master (
      output md_valid, md_ctrl, md_a, md_b, md_cancel,
      input  md_result, md_busy, md_stall, hi, lo
   );

   modport slave (
      input  md_valid, md_ctrl, md_a, md_b, md_cancel,
      output md_result, md_busy, md_stall, hi, lo
   );
`else
   modport master (
      output md_valid, md_ctrl, md_a, md_b,
      input  md_result, md_busy, md_stall, hi, lo
   );

   modport slave (
      input  md_valid, md_ctrl, md_a, md_b,
      output md_result, md_busy, md_stall, hi, lo
   );
`endif
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the ALU.
// Long operations (mult/multu/div/divu) hold md_busy for a fixed latency and
// write HI/LO at the end; mtlo/mthi write immediately; mflo/mfhi read via md_result.
// Optional macro MD_CANCEL_EN adds md_cancel, which flushes an in-flight operation
// and blocks issue in the cycle it is asserted.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   md_unit_if.slave   bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   state_t      next_state;
   logic [31:0] count;
   logic [2:0]  op;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        cancel;
   logic        long_op;
   logic        issue_long;
   logic        write_lo;
   logic        write_hi;
   logic        done;

   logic [63:0] product;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quot_mag;
   logic [31:0] rem_mag;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        div_by_zero;

`ifdef MD_CANCEL_EN
   assign cancel = bus.md_cancel;
`else
   assign cancel = 1'b0;
`endif

   assign long_op = (bus.md_ctrl >= 3'd1) && (bus.md_ctrl <= 3'd4);

   assign bus.md_busy   = (state == BUSY);
   assign bus.md_stall  = bus.md_busy | (bus.md_valid & long_op);
   assign bus.md_result = (bus.md_ctrl == 3'd7) ? hi_q : lo_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

   // Next-state and write-enable decode; anything issued while busy is dropped
   always_comb begin
      next_state = state;
      issue_long = 1'b0;
      write_lo   = 1'b0;
      write_hi   = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.md_valid && !cancel) begin
               if (long_op) begin
                  issue_long = 1'b1;
                  next_state = BUSY;
               end else if (bus.md_ctrl == 3'd5) begin
                  write_lo = 1'b1;
               end else if (bus.md_ctrl == 3'd6) begin
                  write_hi = 1'b1;
               end
            end
         end
         BUSY: begin
            if (cancel) begin
               next_state = IDLE;
            end else if (count == 32'd1) begin
               done       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Arithmetic on the latched operands; signed divide runs on magnitudes so
   // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0
   always_comb begin
      abs_a       = a_q[31] ? (32'd0 - a_q) : a_q;
      abs_b       = b_q[31] ? (32'd0 - b_q) : b_q;
      dividend    = (op == 3'd4) ? abs_a : a_q;
      divisor     = (op == 3'd4) ? abs_b : b_q;
      div_by_zero = (b_q == 32'd0);
      quot_mag    = div_by_zero ? 32'd0 : (dividend / divisor);
      rem_mag     = div_by_zero ? 32'd0 : (dividend % divisor);
      if (op == 3'd2) begin
         product = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      end else begin
         product = {32'd0, a_q} * {32'd0, b_q};
      end
      res_hi = product[63:32];
      res_lo = product[31:0];
      if (op == 3'd3) begin
         res_hi = rem_mag;
         res_lo = quot_mag;
      end else if (op == 3'd4) begin
         res_hi = a_q[31] ? (32'd0 - rem_mag) : rem_mag;
         res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - quot_mag) : quot_mag;
      end
   end

   // State, counter, operand latch and HI/LO registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= 32'd0;
         op    <= 3'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else begin
         state <= next_state;
         if (issue_long) begin
            op    <= bus.md_ctrl;
            a_q   <= bus.md_a;
            b_q   <= bus.md_b;
            count <= (bus.md_ctrl <= 3'd2) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
         end else if (state == BUSY) begin
            count <= count - 32'd1;
         end
         if (write_lo) begin
            lo_q <= bus.md_a;
         end
         if (write_hi) begin
            hi_q <= bus.md_a;
         end
         if (done && !((op >= 3'd3) && div_by_zero)) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected completions/reads,
// a negedge monitor pops and compares when busy falls or a read is issued.
// Cancel scenarios are compiled in when MD_CANCEL_EN is defined.
module tb_md_unit;

   logic clk = 1'b0;
   logic reset = 1'b1;

   md_unit_if bus ();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit          is_read;
      logic [31:0] exp_a;
      logic [31:0] exp_lo;
      int          exp_cycles;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   busy_cnt = 0;
   bit   prev_busy = 1'b0;
   exp_t e;

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic expect_done(input string name, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo, input int cycles);
      exp_t x;
      x.is_read = 1'b0; x.exp_a = exp_hi; x.exp_lo = exp_lo;
      x.exp_cycles = cycles; x.name = name;
      sb.push_back(x);
   endtask

   task automatic expect_read(input string name, input logic [31:0] value);
      exp_t x;
      x.is_read = 1'b1; x.exp_a = value; x.exp_lo = 32'd0;
      x.exp_cycles = 0; x.name = name;
      sb.push_back(x);
   endtask

   // Drive one issue cycle, checking the combinational stall in that cycle
   task automatic apply_stimulus(input logic [2:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b, input logic exp_stall);
      bus.md_valid = 1'b1;
      bus.md_ctrl  = ctrl;
      bus.md_a     = a;
      bus.md_b     = b;
      #1;
      check_output("stall in issue cycle", {31'd0, bus.md_stall}, {31'd0, exp_stall});
      @(posedge clk); #1;
      bus.md_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(posedge clk); #1;
         if (bus.md_busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         $display("[TB] FAIL wait_idle: busy still 1 after %0d cycles, required 0", max_cycles);
      end
   endtask

   // Monitor: count busy cycles, compare on busy fall and on idle reads
   initial begin
      forever begin
         @(negedge clk);
         if (bus.md_busy === 1'b1) begin
            busy_cnt++;
            prev_busy = 1'b1;
         end else if (prev_busy) begin
            prev_busy = 1'b0;
            if (sb.size() == 0 || sb[0].is_read) begin
               n_checks++;
               $display("[TB] FAIL unexpected completion: got busy end, required none");
            end else begin
               e = sb.pop_front();
               check_output({e.name, " hi"}, bus.hi, e.exp_a);
               check_output({e.name, " lo"}, bus.lo, e.exp_lo);
               check_output({e.name, " busy cycles"}, 32'(busy_cnt), 32'(e.exp_cycles));
            end
            busy_cnt = 0;
         end
         if (bus.md_busy === 1'b0 && bus.md_valid === 1'b1 &&
             (bus.md_ctrl == 3'd0 || bus.md_ctrl == 3'd7)) begin
            if (sb.size() == 0 || !sb[0].is_read) begin
               n_checks++;
               $display("[TB] FAIL unexpected read: got read, required none");
            end else begin
               e = sb.pop_front();
               check_output(e.name, bus.md_result, e.exp_a);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus
   initial begin
      bus.md_valid = 1'b0;
      bus.md_ctrl  = 3'd0;
      bus.md_a     = 32'd0;
      bus.md_b     = 32'd0;
`ifdef MD_CANCEL_EN
      bus.md_cancel = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_output("reset hi", bus.hi, 32'd0);
      check_output("reset lo", bus.lo, 32'd0);
      check_output("reset busy", {31'd0, bus.md_busy}, 32'd0);

      apply_stimulus(3'd5, 32'h12345678, 32'd0, 1'b0);
      expect_read("mflo after mtlo", 32'h12345678);
      apply_stimulus(3'd0, 32'd0, 32'd0, 1'b0);
      check_output("hi after mtlo", bus.hi, 32'd0);

      expect_done("mult -2*3", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      apply_stimulus(3'd2, 32'hFFFFFFFE, 32'd3, 1'b1);
      wait_idle(20);

      expect_done("multu", 32'h00000002, 32'hFFFFFFFA, 5);
      apply_stimulus(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
      wait_idle(20);

      expect_done("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      apply_stimulus(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1);
      wait_idle(20);

      expect_done("divu by zero", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      apply_stimulus(3'd3, 32'd7, 32'd0, 1'b1);
      wait_idle(20);

      expect_done("div overflow", 32'd0, 32'h80000000, 10);
      apply_stimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      wait_idle(20);

      expect_done("mult 4x4", 32'd0, 32'd16, 5);
      apply_stimulus(3'd2, 32'd4, 32'd4, 1'b1);
      wait_idle(20);
      apply_stimulus(3'd5, 32'h00000055, 32'd0, 1'b0);
      expect_read("mflo back-to-back", 32'h00000055);
      apply_stimulus(3'd0, 32'd0, 32'd0, 1'b0);
      expect_read("mfhi back-to-back", 32'd0);
      apply_stimulus(3'd7, 32'd0, 32'd0, 1'b0);

      expect_done("mult ignores mthi", 32'd0, 32'd42, 5);
      apply_stimulus(3'd2, 32'd7, 32'd6, 1'b1);
      @(posedge clk); #1;
      bus.md_valid = 1'b1;
      bus.md_ctrl  = 3'd6;
      bus.md_a     = 32'hAAAA5555;
      bus.md_b     = 32'h0000FFFF;
      @(posedge clk); #1;
      bus.md_valid = 1'b0;
      wait_idle(20);

      expect_done("reset mid div", 32'd0, 32'd0, 3);
      apply_stimulus(3'd4, 32'd100, 32'd3, 1'b1);
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      expect_read("mflo after reset", 32'd0);
      apply_stimulus(3'd0, 32'd0, 32'd0, 1'b0);

`ifdef MD_CANCEL_EN
      apply_stimulus(3'd6, 32'h00000011, 32'd0, 1'b0);
      expect_done("cancel cycle 4", 32'h00000011, 32'd0, 4);
      apply_stimulus(3'd2, 32'd4, 32'd4, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      bus.md_cancel = 1'b1;
      @(posedge clk); #1;
      bus.md_cancel = 1'b0;
      check_output("busy after cancel", {31'd0, bus.md_busy}, 32'd0);

      expect_done("cancel final cycle", 32'h00000011, 32'd0, 5);
      apply_stimulus(3'd2, 32'd4, 32'd4, 1'b1);
      repeat (4) begin
         @(posedge clk); #1;
      end
      bus.md_cancel = 1'b1;
      @(posedge clk); #1;
      bus.md_cancel = 1'b0;

      bus.md_cancel = 1'b1;
      apply_stimulus(3'd5, 32'h00000099, 32'd0, 1'b0);
      bus.md_cancel = 1'b0;
      expect_read("mflo after blocked mtlo", 32'd0);
      apply_stimulus(3'd0, 32'd0, 32'd0, 1'b0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check_output("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide responder with HI/LO registers.
- Consumes the 3-bit MD operation code issued by the ALU controller and executes it: multiply, divide, move-to-HI/LO, and read of HI/LO.
- Sits beside the ALU in EX.
- Exposes busy/stall status so the hazard unit can hold dependent instructions.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range ≥1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range ≥1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- md_valid  input  1  the md_ctrl operation is issued this cycle.
- md_ctrl  input  3  operation: 0 mflo, 1 multu, 2 mult, 3 divu, 4 div, 5 mtlo, 6 mthi, 7 mfhi.
- md_a  input  32  operand A (rs); the source value for mtlo/mthi.
- md_b  input  32  operand B (rt).
- md_result  output  32  read data: HI when md_ctrl==7, otherwise LO (combinational).
- md_busy  output  1  an operation is in flight.
- md_stall  output  1  md_busy | (md_valid & md_ctrl in 1..4).
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (synchronous, active-high):
  - HI=0, LO=0, md_busy=0, cycle counter=0, state=IDLE.
  - Reset asserted mid-operation discards the operation; HI/LO are still cleared.
- States: IDLE, BUSY.
- IDLE, with md_valid and md_ctrl in 1..4:
  - Latch md_a, md_b and the op code.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; md_busy is high from the next cycle.
- IDLE, with md_valid and md_ctrl 5 (mtlo): LO <= md_a at this edge. Ctrl 6 (mthi): HI <= md_a at this edge. No busy.
- IDLE, with md_valid and md_ctrl 0 or 7: no state change; md_result carries the read.
- BUSY:
  - The counter decrements each cycle.
  - md_busy is high for exactly N cycles, where N is MULT_CYCLES or DIV_CYCLES.
  - At the edge ending the Nth busy cycle, HI/LO are written and the state returns to IDLE.
  - New HI/LO values are visible in the first cycle md_busy is low.
- md_valid while BUSY, any code: ignored; no HI/LO write and no restart. The upstream stage must hold on md_stall.
- md_result while BUSY returns the old HI/LO.
- Arithmetic:
  - multu: {HI,LO} = unsigned 32x32 -> 64 product.
  - mult: signed 64-bit product.
  - divu: LO = unsigned quotient, HI = unsigned remainder.
  - div: quotient truncated toward zero; remainder takes the sign of the dividend.
- div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divisor 0 (div or divu): full busy latency still elapses; HI and LO are left unchanged.
- Operands are latched at issue; later changes to md_a/md_b have no effect on the in-flight operation.
- md_stall is combinational and asserts in the issue cycle itself, so a dependent mfhi/mflo immediately behind the operation stalls.
- Back-to-back:
  - An op issued in the first idle cycle after completion is accepted.
  - mtlo in that cycle overwrites the freshly written LO.

Optional Feature:
- Macro MD_CANCEL_EN.
- When defined:
  - Adds input md_cancel (1 bit).
  - md_cancel high while BUSY returns the unit to IDLE at that edge; HI/LO keep their pre-operation values and md_busy is low next cycle.
  - md_cancel high in IDLE blocks any issue in that same cycle, including mtlo/mthi.
  - md_cancel takes priority over completion when both fall on the same edge.
  - Used for exception flush.
- When undefined: no md_cancel port; operations always run to completion.

Test Plan:
- Reset, then mtlo with md_a=0x12345678, then mflo -> md_result=0x12345678, hi=0, md_busy never asserted.
- mult with md_a=0xFFFFFFFE (-2), md_b=3 -> md_stall=1 in the issue cycle; md_busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div with md_a=0xFFFFFFF9 (-7), md_b=2 -> md_busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> 10 busy cycles, HI/LO unchanged. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue mult, then on busy cycle 2 drive md_valid with mthi (md_a=0xAAAA5555) and change md_a/md_b -> mthi ignored; result equals the original operands' product.
- Reset asserted on busy cycle 3 of a div -> next cycle md_busy=0, hi=lo=0; mflo returns 0.
- With MD_CANCEL_EN: mthi 0x11, then mult 4x4, md_cancel on busy cycle 4 -> md_busy=0 next cycle, hi=0x11, lo=0. A cancel coinciding with the final busy cycle also leaves HI/LO unchanged.
